// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types: result packet, retirement trace, and the combined entry
// that FIFO slots and broadcast ports both carry.
package cdb_arbiter_pkg;

    localparam int unsigned CDB_TAG_W       = 4;
    localparam int unsigned NUM_CDB_DEFAULT = 2;

    typedef struct packed {
        logic                 valid;
        logic [CDB_TAG_W-1:0] tag;
        logic [31:0]          value;
        logic                 br_en;
        logic [31:0]          br_target;
    } cdb_t;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
    } rvfi_data;

    typedef struct packed {
        cdb_t     pkt;
        rvfi_data rvfi;
    } cdb_port_t;

    // (a + b) mod m for operands already known to satisfy a + b < 2m.
    function automatic int wrap_add(input int a, input int b, input int m);
        int s;
        s = a + b;
        return (s >= m) ? (s - m) : s;
    endfunction

endpackage

// File: rtl/cdb_fu_fifo.sv
// Per-channel result FIFO. Pointers wrap explicitly at DEPTH-1, so any depth
// works; a full FIFO refuses a push even when it is popped in the same cycle.
module cdb_fu_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_flush,
    input  logic      i_push,
    input  logic      i_pop,
    input  cdb_port_t i_data,
    output cdb_port_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    cdb_port_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: NUM_FU buffered result channels onto NUM_CDB ports.
// Define CDB_BYPASS_EN for zero-latency bypass of empty channels (combinational cdb_out).
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_FU     = 4,
    parameter int unsigned NUM_CDB    = NUM_CDB_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned TAG_W      = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_flush,
    input  logic     [NUM_FU-1:0]     i_fu_valid,
    output logic     [NUM_FU-1:0]     o_fu_ready,
    input  cdb_t     [NUM_FU-1:0]     i_fu_pkt,
    input  rvfi_data [NUM_FU-1:0]     i_fu_rvfi,
    output cdb_t     [NUM_CDB-1:0]    o_cdb_out,
    output rvfi_data [NUM_CDB-1:0]    o_cdb_rvfi,
    output logic     [NUM_FU-1:0]     o_fu_overflow
);

    // Elaboration divides by zero if TAG_W disagrees with the packet's tag field.
    localparam int unsigned TAG_W_OK = 1 / ((TAG_W == CDB_TAG_W) ? 1 : 0);
    localparam int unsigned RR_W     = ((NUM_FU > 1) ? $clog2(NUM_FU) : 1) * TAG_W_OK;

    logic      [NUM_FU-1:0]  w_full;
    logic      [NUM_FU-1:0]  w_empty;
    logic      [NUM_FU-1:0]  w_push;
    logic      [NUM_FU-1:0]  w_pop;
    logic      [NUM_FU-1:0]  w_cand;
    logic      [NUM_FU-1:0]  w_grant;
    logic                    w_any_grant;
    cdb_port_t [NUM_FU-1:0]  w_in;
    cdb_port_t [NUM_FU-1:0]  w_fifo_head;
    cdb_port_t [NUM_FU-1:0]  w_src;
    cdb_port_t [NUM_CDB-1:0] w_port;
    int                      w_rank [NUM_FU];
    logic      [RR_W-1:0]    w_rr_next;
    logic      [RR_W-1:0]    r_rr_ptr;
    logic      [NUM_FU-1:0]  r_overflow;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FU; gi++) begin : g_chan
            assign w_in[gi] = '{pkt: i_fu_pkt[gi], rvfi: i_fu_rvfi[gi]};
`ifdef CDB_BYPASS_EN
            // An empty channel with a live input competes directly; if it wins,
            // the packet goes straight to the port and skips the FIFO.
            assign w_cand[gi] = !w_empty[gi] || i_fu_valid[gi];
            assign w_src[gi]  = w_empty[gi] ? w_in[gi] : w_fifo_head[gi];
            assign w_push[gi] = i_fu_valid[gi] && !(w_grant[gi] && w_empty[gi]);
`else
            assign w_cand[gi] = !w_empty[gi];
            assign w_src[gi]  = w_fifo_head[gi];
            assign w_push[gi] = i_fu_valid[gi];
`endif
            assign w_pop[gi] = w_grant[gi] && !w_empty[gi];

            cdb_fu_fifo #(
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_flush (i_flush),
                .i_push  (w_push[gi]),
                .i_pop   (w_pop[gi]),
                .i_data  (w_in[gi]),
                .o_head  (w_fifo_head[gi]),
                .o_full  (w_full[gi]),
                .o_empty (w_empty[gi])
            );
        end
    endgenerate

    assign o_fu_ready    = ~w_full;
    assign o_fu_overflow = r_overflow;

    // Rank = number of candidates ahead of this channel in the scan from r_rr_ptr;
    // the first NUM_CDB ranks win and rank k drives port k.
    always_comb begin
        int off [NUM_FU];
        int rank;
        int max_off;
        w_grant     = '0;
        w_any_grant = 1'b0;
        max_off     = 0;
        rank        = 0;
        for (int i = 0; i < int'(NUM_FU); i++) begin
            off[i] = wrap_add(i, int'(NUM_FU) - int'(r_rr_ptr), int'(NUM_FU));
        end
        for (int i = 0; i < int'(NUM_FU); i++) begin
            rank = 0;
            for (int j = 0; j < int'(NUM_FU); j++) begin
                if (w_cand[j] && (off[j] < off[i])) rank = rank + 1;
            end
            w_rank[i] = rank;
            if (w_cand[i] && (rank < int'(NUM_CDB))) begin
                w_grant[i]  = 1'b1;
                w_any_grant = 1'b1;
                if (off[i] > max_off) max_off = off[i];
            end
        end
        w_rr_next = RR_W'(wrap_add(int'(r_rr_ptr), max_off + 1, int'(NUM_FU)));
    end

    always_comb begin
        for (int k = 0; k < int'(NUM_CDB); k++) begin
            w_port[k] = '0;
            for (int i = 0; i < int'(NUM_FU); i++) begin
                if (w_grant[i] && (w_rank[i] == k)) w_port[k] = w_src[i];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_ptr <= '0;
        end else if (i_flush) begin
            r_rr_ptr <= '0;
        end else if (w_any_grant) begin
            r_rr_ptr <= w_rr_next;
        end
    end

    // Overflow survives flush; only reset clears it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow <= '0;
        end else begin
            r_overflow <= r_overflow | (i_fu_valid & w_full);
        end
    end

`ifdef CDB_BYPASS_EN
    always_comb begin
        for (int k = 0; k < int'(NUM_CDB); k++) begin
            o_cdb_out[k]  = i_flush ? '0 : w_port[k].pkt;
            o_cdb_rvfi[k] = i_flush ? '0 : w_port[k].rvfi;
        end
    end
`else
    cdb_t     [NUM_CDB-1:0] r_cdb_out;
    rvfi_data [NUM_CDB-1:0] r_cdb_rvfi;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cdb_out  <= '0;
            r_cdb_rvfi <= '0;
        end else if (i_flush) begin
            r_cdb_out  <= '0;
            r_cdb_rvfi <= '0;
        end else begin
            for (int k = 0; k < int'(NUM_CDB); k++) begin
                r_cdb_out[k]  <= w_port[k].pkt;
                r_cdb_rvfi[k] <= w_port[k].rvfi;
            end
        end
    end

    assign o_cdb_out  = r_cdb_out;
    assign o_cdb_rvfi = r_cdb_rvfi;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter (default build): cycle vector table, hand sequences for
// passthrough and async reset, then random traffic against a queue-based model.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NF  = 4;
    localparam int NC  = 2;
    localparam int DEP = 2;

    logic                clk      = 1'b0;
    logic                rst_n    = 1'b0;
    logic                flush    = 1'b0;
    logic     [NF-1:0]   fu_valid = '0;
    cdb_t     [NF-1:0]   fu_pkt   = '0;
    rvfi_data [NF-1:0]   fu_rvfi  = '0;
    logic     [NF-1:0]   fu_ready;
    cdb_t     [NC-1:0]   cdb_out;
    rvfi_data [NC-1:0]   cdb_rvfi;
    logic     [NF-1:0]   fu_overflow;

    int n_cmp = 0;
    int n_bad = 0;

    cdb_arbiter #(
        .NUM_FU     (NF),
        .NUM_CDB    (NC),
        .FIFO_DEPTH (DEP),
        .TAG_W      (4)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_flush       (flush),
        .i_fu_valid    (fu_valid),
        .o_fu_ready    (fu_ready),
        .i_fu_pkt      (fu_pkt),
        .i_fu_rvfi     (fu_rvfi),
        .o_cdb_out     (cdb_out),
        .o_cdb_rvfi    (cdb_rvfi),
        .o_fu_overflow (fu_overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        fl;
        logic [3:0]  v;
        logic [15:0] tags;   // nibble i = tag pushed on channel i
        logic [1:0]  ev;     // expected port valids
        logic [7:0]  et;     // nibble k = expected tag on port k
        logic [3:0]  er;
        logic [3:0]  eo;
    } vec_t;

    vec_t      tbl [15];
    cdb_port_t mq [NF][$];
    int        m_rr;
    logic [NF-1:0] m_ovf;

    function automatic cdb_port_t mk_tagged(input logic [3:0] tag);
        cdb_port_t p;
        p.pkt.valid      = 1'b1;
        p.pkt.tag        = tag;
        p.pkt.value      = {28'hC0DE000, tag};
        p.pkt.br_en      = tag[0];
        p.pkt.br_target  = {tag, 28'h0000ABC};
        p.rvfi.insn      = {28'h0000013, tag};
        p.rvfi.pc_rdata  = {20'h00010, tag, 8'h00};
        p.rvfi.pc_wdata  = {20'h00010, tag, 8'h04};
        p.rvfi.rd_addr   = {1'b1, tag};
        p.rvfi.rd_wdata  = {tag, 28'h5A5A5A5};
        return p;
    endfunction

    task automatic drive(input logic fl, input logic [3:0] v, input logic [15:0] tags);
        cdb_port_t p;
        flush = fl;
        for (int i = 0; i < NF; i++) begin
            p = mk_tagged(tags[4*i +: 4]);
            fu_valid[i] = v[i];
            fu_pkt[i]   = p.pkt;
            fu_rvfi[i]  = p.rvfi;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_port(input string nm, input int k, input cdb_port_t exp);
        cdb_port_t got;
        got.pkt  = cdb_out[k];
        got.rvfi = cdb_rvfi[k];
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s port%0d: got v=%0b tag=%h data=%h, required v=%0b tag=%h data=%h",
                     nm, k, got.pkt.valid, got.pkt.tag, got, exp.pkt.valid, exp.pkt.tag, exp);
        end
    endtask

    task automatic chk_bits(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, got, exp);
        end
    endtask

    // Behavioural model: per-channel queues, a scan that starts at m_rr and takes
    // the first NC non-empty heads, then pushes of inputs that saw room.
    task automatic model_step(output cdb_port_t [NC-1:0] exp);
        logic [NF-1:0] rdy;
        int n;
        int last;
        cdb_port_t p;
        exp = '0;
        for (int i = 0; i < NF; i++) begin
            rdy[i] = (mq[i].size() < DEP);
            if (fu_valid[i] && !rdy[i]) m_ovf[i] = 1'b1;
        end
        if (flush) begin
            for (int i = 0; i < NF; i++) mq[i].delete();
            m_rr = 0;
            return;
        end
        n    = 0;
        last = -1;
        for (int s = 0; s < NF; s++) begin
            int c;
            c = (m_rr + s) % NF;
            if (n < NC && mq[c].size() > 0) begin
                exp[n] = mq[c].pop_front();
                n++;
                last = c;
            end
        end
        for (int i = 0; i < NF; i++) begin
            if (fu_valid[i] && rdy[i]) begin
                p.pkt  = fu_pkt[i];
                p.rvfi = fu_rvfi[i];
                mq[i].push_back(p);
            end
        end
        if (last >= 0) m_rr = (last + 1) % NF;
    endtask

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        cdb_port_t [NC-1:0] expv;
        cdb_port_t ex;
        cdb_port_t br;
        logic [NF-1:0] erdy;

        //          fl    v      tags      ev     et     er     eo
        tbl[0]  = '{1'b0, 4'hF, 16'h4321, 2'b00, 8'h00, 4'hF, 4'h0};  // all four push
        tbl[1]  = '{1'b0, 4'h0, 16'h0000, 2'b11, 8'h21, 4'hF, 4'h0};
        tbl[2]  = '{1'b0, 4'h0, 16'h0000, 2'b11, 8'h43, 4'hF, 4'h0};
        tbl[3]  = '{1'b0, 4'h0, 16'h0000, 2'b00, 8'h00, 4'hF, 4'h0};
        tbl[4]  = '{1'b0, 4'hF, 16'h4521, 2'b00, 8'h00, 4'hF, 4'h0};  // fill FU2
        tbl[5]  = '{1'b0, 4'h7, 16'h0698, 2'b11, 8'h21, 4'hB, 4'h0};
        tbl[6]  = '{1'b0, 4'h4, 16'h0700, 2'b11, 8'h45, 4'hF, 4'h4};  // push while full
        tbl[7]  = '{1'b0, 4'h4, 16'h0700, 2'b11, 8'h98, 4'hB, 4'h4};  // held push retried
        tbl[8]  = '{1'b0, 4'h0, 16'h0000, 2'b01, 8'h06, 4'hF, 4'h4};
        tbl[9]  = '{1'b0, 4'h0, 16'h0000, 2'b01, 8'h07, 4'hF, 4'h4};
        tbl[10] = '{1'b0, 4'h0, 16'h0000, 2'b00, 8'h00, 4'hF, 4'h4};
        tbl[11] = '{1'b0, 4'h7, 16'h0321, 2'b00, 8'h00, 4'hF, 4'h4};  // buffer three
        tbl[12] = '{1'b1, 4'h2, 16'h0070, 2'b00, 8'h00, 4'hF, 4'h4};  // flush + tag 7
        tbl[13] = '{1'b0, 4'h0, 16'h0000, 2'b00, 8'h00, 4'hF, 4'h4};
        tbl[14] = '{1'b0, 4'h0, 16'h0000, 2'b00, 8'h00, 4'hF, 4'h4};

        #1;
        for (int k = 0; k < NC; k++) chk_port("reset_out", k, '0);
        chk_bits("reset_ready", 32'(fu_ready), 32'hF);
        chk_bits("reset_ovf", 32'(fu_overflow), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 15; r++) begin
            drive(tbl[r].fl, tbl[r].v, tbl[r].tags);
            tick();
            for (int k = 0; k < NC; k++) begin
                ex = tbl[r].ev[k] ? mk_tagged(tbl[r].et[4*k +: 4]) : '0;
                chk_port($sformatf("row%0d", r), k, ex);
            end
            chk_bits($sformatf("row%0d_ready", r), 32'(fu_ready), 32'(tbl[r].er));
            chk_bits($sformatf("row%0d_ovf", r), 32'(fu_overflow), 32'(tbl[r].eo));
            $display("row %0d flush=%0b valid=%b -> p0 v=%0b tag=%h p1 v=%0b tag=%h ready=%b ovf=%b",
                     r, tbl[r].fl, tbl[r].v, cdb_out[0].valid, cdb_out[0].tag,
                     cdb_out[1].valid, cdb_out[1].tag, fu_ready, fu_overflow);
        end

        // Branch result on the CMP channel must come out bit-exact on port 0.
        br.pkt.valid     = 1'b1;
        br.pkt.tag       = 4'hA;
        br.pkt.value     = 32'h8000_0004;
        br.pkt.br_en     = 1'b1;
        br.pkt.br_target = 32'h0000_1234;
        br.rvfi.insn     = 32'h0040_0063;
        br.rvfi.pc_rdata = 32'h0000_1000;
        br.rvfi.pc_wdata = 32'h0000_1234;
        br.rvfi.rd_addr  = 5'd0;
        br.rvfi.rd_wdata = 32'h8000_0004;
        drive(1'b0, 4'h0, 16'h0);
        fu_valid[2] = 1'b1;
        fu_pkt[2]   = br.pkt;
        fu_rvfi[2]  = br.rvfi;
        tick();
        chk_port("branch_push_cycle", 0, '0);
        fu_valid = '0;
        tick();
        chk_port("branch_pass", 0, br);
        chk_port("branch_port1", 1, '0);
        $display("branch: p0 tag=%h value=%h br_en=%0b br_target=%h", cdb_out[0].tag,
                 cdb_out[0].value, cdb_out[0].br_en, cdb_out[0].br_target);

        // Async reset mid-burst with several FIFOs partly occupied (rr_ptr is 3 here).
        drive(1'b0, 4'hF, 16'h4321);
        tick();
        drive(1'b0, 4'hF, 16'hCBA9);
        tick();
        chk_port("burst_p0", 0, mk_tagged(4'h4));
        chk_port("burst_p1", 1, mk_tagged(4'h1));
        drive(1'b0, 4'h0, 16'h0);
        #3;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NC; k++) chk_port("async_rst_out", k, '0);
        chk_bits("async_rst_ready", 32'(fu_ready), 32'hF);
        chk_bits("async_rst_ovf", 32'(fu_overflow), 32'h0);
        $display("async reset: p0 v=%0b p1 v=%0b ready=%b ovf=%b", cdb_out[0].valid,
                 cdb_out[1].valid, fu_ready, fu_overflow);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            for (int k = 0; k < NC; k++) chk_port($sformatf("post_rst%0d", c), k, '0);
        end

        // Random traffic: sources mostly honour ready, occasionally force a push.
        for (int i = 0; i < NF; i++) mq[i].delete();
        m_rr  = 0;
        m_ovf = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            flush = ($urandom_range(31) == 0);
            for (int i = 0; i < NF; i++) begin
                fu_valid[i] = fu_ready[i] ? ($urandom_range(9) < 6) : ($urandom_range(15) == 0);
                fu_pkt[i].valid     = 1'b1;
                fu_pkt[i].tag       = 4'($urandom);
                fu_pkt[i].value     = $urandom;
                fu_pkt[i].br_en     = 1'($urandom);
                fu_pkt[i].br_target = $urandom;
                fu_rvfi[i].insn     = $urandom;
                fu_rvfi[i].pc_rdata = $urandom;
                fu_rvfi[i].pc_wdata = $urandom;
                fu_rvfi[i].rd_addr  = 5'($urandom);
                fu_rvfi[i].rd_wdata = $urandom;
            end
            model_step(expv);
            tick();
            for (int k = 0; k < NC; k++) chk_port($sformatf("rand%0d", cyc), k, expv[k]);
            for (int i = 0; i < NF; i++) erdy[i] = (mq[i].size() < DEP);
            chk_bits($sformatf("rand%0d_ready", cyc), 32'(fu_ready), 32'(erdy));
            chk_bits($sformatf("rand%0d_ovf", cyc), 32'(fu_overflow), 32'(m_ovf));
            $display("rand %0d flush=%0b valid=%b -> p0 v=%0b tag=%h p1 v=%0b tag=%h ready=%b",
                     cyc, flush, fu_valid, cdb_out[0].valid, cdb_out[0].tag,
                     cdb_out[1].valid, cdb_out[1].tag, fu_ready);
        end
        fu_valid = '0;
        flush    = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
